// File: rtl/mul_result_combine.sv
// Recombines the four 16x16 partial products into a 64-bit product over the
// M->A->W pipeline and delivers the selected 32-bit word to writeback.
module mul_result_combine (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] M_mul_cell_p1,
   input  logic [31:0] M_mul_cell_p2,
   input  logic [31:0] M_mul_cell_p3,
   input  logic [31:0] M_mul_cell_p4,
   input  logic        M_mul_valid,
   input  logic        M_ctrl_mul_hi,
   input  logic        M_ctrl_mul_src1_signed,
   input  logic        M_ctrl_mul_src2_signed,
   input  logic        A_en,
   input  logic        W_en,
   input  logic        A_pipe_flush,
   output logic [31:0] W_mul_result,
   output logic        W_mul_valid
);

   logic [33:0] p2_ext;
   logic [33:0] p3_ext;
   logic [33:0] mid;
   logic [32:0] lo33;

   logic [31:0] a_lo;
   logic        a_cy;
   logic [17:0] a_mid_hi;
   logic [31:0] a_p4;
   logic        a_hi_sel;
   logic        a_valid;

   logic [31:0] hi;

   // p2 and p3 overlap at bit 16, so they are summed first and the lower
   // 16 bits of that sum folded into the low word together with p1.
   always_comb begin
      p2_ext = {{2{M_ctrl_mul_src2_signed & M_mul_cell_p2[31]}}, M_mul_cell_p2};
      p3_ext = {{2{M_ctrl_mul_src1_signed & M_mul_cell_p3[31]}}, M_mul_cell_p3};
      mid    = p2_ext + p3_ext;
      lo33   = {1'b0, M_mul_cell_p1} + {1'b0, mid[15:0], 16'h0000};
   end

   // p4 only contributes to bits 63:32, so its extension above bit 31 never
   // reaches either selectable word and is not carried into A.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_lo     <= '0;
         a_cy     <= 1'b0;
         a_mid_hi <= '0;
         a_p4     <= '0;
         a_hi_sel <= 1'b0;
         a_valid  <= 1'b0;
      end else if (A_en) begin
         a_lo     <= lo33[31:0];
         a_cy     <= lo33[32];
         a_mid_hi <= mid[33:16];
         a_p4     <= M_mul_cell_p4;
         a_hi_sel <= M_ctrl_mul_hi;
         a_valid  <= M_mul_valid & ~A_pipe_flush;
      end
   end

   always_comb begin
      hi = a_p4 + {{14{a_mid_hi[17]}}, a_mid_hi} + {31'b0, a_cy};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         W_mul_result <= '0;
         W_mul_valid  <= 1'b0;
      end else if (W_en) begin
         W_mul_result <= a_hi_sel ? hi : a_lo;
         W_mul_valid  <= a_valid;
      end
   end

endmodule
